// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module  : cpu_pkg
//  Brief   : Shared register-file constants, types and a popcount helper.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [ADDR_W:0]   reg_cnt_t;
  typedef logic [NUM_REGS-1:0] busy_vec_t;

  function automatic reg_cnt_t popcount(input busy_vec_t v);
    reg_cnt_t c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + reg_cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
//  Module  : reg_scoreboard
//  Brief   : Per-register busy bits, RAW stall detection and busy popcount.
//            Optional macro WB_BYPASS_EN masks stall on a same-cycle write-back.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  input  logic      issue_valid,
  input  reg_addr_t issue_dest,
  input  logic      squash_valid,
  input  reg_addr_t squash_dest,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  output logic      stall,
  output reg_cnt_t  busy_cnt
);

  busy_vec_t r_busy;
  busy_vec_t w_busy_nxt;
  reg_cnt_t  r_busy_cnt;
  logic      w_rs_busy;
  logic      w_rt_busy;

  // A new producer outranks a retiring or squashed one on the same register.
  always_comb begin
    w_busy_nxt    = r_busy;
    w_busy_nxt[0] = 1'b0;
    for (int a = 1; a < NUM_REGS; a++) begin
      if (issue_valid && (issue_dest == reg_addr_t'(a))) begin
        w_busy_nxt[a] = 1'b1;
      end else if ((wb_en && (wb_addr == reg_addr_t'(a))) ||
                   (squash_valid && (squash_dest == reg_addr_t'(a)))) begin
        w_busy_nxt[a] = 1'b0;
      end
    end
  end

  always_comb begin
    w_rs_busy = r_busy[rs_addr] && (rs_addr != '0);
    w_rt_busy = r_busy[rt_addr] && (rt_addr != '0);
`ifdef WB_BYPASS_EN
    if (wb_en && (wb_addr == rs_addr)) begin
      w_rs_busy = 1'b0;
    end
    if (wb_en && (wb_addr == rt_addr)) begin
      w_rt_busy = 1'b0;
    end
`endif
  end

  assign stall    = w_rs_busy || w_rt_busy;
  assign busy_cnt = r_busy_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= popcount(w_busy_nxt);
    end
  end

endmodule : reg_scoreboard

`default_nettype wire

// File: rtl/regfile_wb_port.sv
// ============================================================================
//  Module  : regfile_wb_port
//  Brief   : Register file with write-back port, two combinational read ports
//            and a RAW scoreboard. Optional macro WB_BYPASS_EN adds write-through.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_port
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output word_t     data1R,
  output word_t     data2R,
  input  logic      issue_valid,
  input  reg_addr_t issue_dest,
  input  logic      squash_valid,
  input  reg_addr_t squash_dest,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  word_t     wb_data,
  output logic      stall,
  output reg_cnt_t  busy_cnt
);

  word_t r_regs [NUM_REGS];
  logic  w_wr_en;

  assign w_wr_en = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    data1R = (rs_addr == '0) ? '0 : r_regs[rs_addr];
    data2R = (rt_addr == '0) ? '0 : r_regs[rt_addr];
`ifdef WB_BYPASS_EN
    if (w_wr_en && (wb_addr == rs_addr)) begin
      data1R = wb_data;
    end
    if (w_wr_en && (wb_addr == rt_addr)) begin
      data2R = wb_data;
    end
`endif
  end

  reg_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .squash_valid (squash_valid),
    .squash_dest  (squash_dest),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .stall        (stall),
    .busy_cnt     (busy_cnt)
  );

endmodule : regfile_wb_port

`default_nettype wire

// File: tb/tb_regfile_wb_port.sv
// ============================================================================
//  Module  : tb_regfile_wb_port
//  Brief   : Directed self-checking bench for regfile_wb_port (honours WB_BYPASS_EN).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_port;
  import cpu_pkg::*;

  logic      clk;
  logic      rst_n;
  reg_addr_t rs_addr;
  reg_addr_t rt_addr;
  word_t     data1R;
  word_t     data2R;
  logic      issue_valid;
  reg_addr_t issue_dest;
  logic      squash_valid;
  reg_addr_t squash_dest;
  logic      wb_en;
  reg_addr_t wb_addr;
  word_t     wb_data;
  logic      stall;
  reg_cnt_t  busy_cnt;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_wb_port dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .data1R       (data1R),
    .data2R       (data2R),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .squash_valid (squash_valid),
    .squash_dest  (squash_dest),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .stall        (stall),
    .busy_cnt     (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, well clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_dest   = '0;
    squash_valid = 1'b0;
    squash_dest  = '0;
    wb_en        = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
  endtask

  // Issues must never be presented while decode is stalled.
  task automatic issue(input reg_addr_t d);
    idle();
    issue_valid = 1'b1;
    issue_dest  = d;
    #1;
    chk("issue_protocol_stall", 32'(stall), 32'd0);
    tick();
    idle();
  endtask

  initial begin
    rst_n   = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
    idle();
    tick();
    tick();

    // Reset state
    rs_addr = 5'd5;
    #1;
    chk("reset_data1R", data1R, 32'h0);
    chk("reset_data2R", data2R, 32'h0);
    chk("reset_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. Mid-operation reset clears data and busy bits; pending events lost
    rs_addr = '0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    idle();
    issue(5'd10);
    rs_addr = 5'd5; rt_addr = 5'd10;
    #1;
    chk("t1_pre_data1R", data1R, 32'hDEADBEEF);
    chk("t1_pre_busy_cnt", 32'(busy_cnt), 32'd1);
    chk("t1_pre_stall", 32'(stall), 32'd1);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1111;
    issue_valid = 1'b1; issue_dest = 5'd11;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_data1R", data1R, 32'h0);
    chk("t1_rst_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("t1_rst_stall", 32'(stall), 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    chk("t1_after_data1R", data1R, 32'h0);
    chk("t1_after_busy_cnt", 32'(busy_cnt), 32'd0);
    rt_addr = 5'd11;
    #1;
    chk("t1_after_stall", 32'(stall), 32'd0);

    // 2. Write then read; same-cycle read depends on bypass
    rs_addr = 5'd7; rt_addr = '0;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678;
    #1;
    chk("t2_same_cycle_data1R", data1R, BYP ? 32'h12345678 : 32'h0);
    tick();
    idle();
    #1;
    chk("t2_data1R", data1R, 32'h12345678);
    chk("t2_data2R", data2R, 32'h0);

    // 3. RAW hazard on r9
    rs_addr = '0; rt_addr = '0;
    issue(5'd9);
    rs_addr = 5'd9;
    #1;
    chk("t3_stall_busy", 32'(stall), 32'd1);
    chk("t3_busy_cnt", 32'(busy_cnt), 32'd1);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5;
    #1;
    chk("t3_wb_cycle_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
    chk("t3_wb_cycle_data1R", data1R, BYP ? 32'hA5 : 32'h0);
    tick();
    idle();
    #1;
    chk("t3_after_stall", 32'(stall), 32'd0);
    chk("t3_after_data1R", data1R, 32'hA5);
    chk("t3_after_busy_cnt", 32'(busy_cnt), 32'd0);

    // 4. Issue and write-back of r3 on the same edge: new producer wins
    rs_addr = '0;
    issue(5'd3);
    issue_valid = 1'b1; issue_dest = 5'd3;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1;
    tick();
    idle();
    rs_addr = 5'd3;
    #1;
    chk("t4_data1R", data1R, 32'h1);
    chk("t4_stall", 32'(stall), 32'd1);
    chk("t4_busy_cnt", 32'(busy_cnt), 32'd1);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h2;
    tick();
    idle();
    chk("t4_retire_busy_cnt", 32'(busy_cnt), 32'd0);

    // 5. Squash; also issue beats squash on the same register
    rs_addr = '0;
    issue(5'd4);
    issue(5'd6);
    chk("t5_busy_cnt_2", 32'(busy_cnt), 32'd2);
    squash_valid = 1'b1; squash_dest = 5'd4;
    tick();
    idle();
    chk("t5_busy_cnt_1", 32'(busy_cnt), 32'd1);
    rs_addr = 5'd4; rt_addr = '0;
    #1;
    chk("t5_rs4_stall", 32'(stall), 32'd0);
    rt_addr = 5'd6;
    #1;
    chk("t5_rt6_stall", 32'(stall), 32'd1);
    rs_addr = '0; rt_addr = '0;
    issue_valid = 1'b1; issue_dest = 5'd6;
    squash_valid = 1'b1; squash_dest = 5'd6;
    tick();
    idle();
    chk("t5_issue_beats_squash", 32'(busy_cnt), 32'd1);
    squash_valid = 1'b1; squash_dest = 5'd6;
    tick();
    idle();
    chk("t5_all_squashed", 32'(busy_cnt), 32'd0);

    // 6. r0 rules
    issue(5'd0);
    chk("t6_issue_r0_busy_cnt", 32'(busy_cnt), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    rs_addr = '0; rt_addr = '0;
    #1;
    chk("t6_wb_cycle_data1R", data1R, 32'h0);
    tick();
    idle();
    #1;
    chk("t6_data1R", data1R, 32'h0);
    chk("t6_data2R", data2R, 32'h0);
    chk("t6_stall", 32'(stall), 32'd0);
    chk("t6_busy_cnt", 32'(busy_cnt), 32'd0);

    // Multiple busy registers, both read ports
    issue(5'd1);
    issue(5'd2);
    issue(5'd31);
    chk("multi_busy_cnt", 32'(busy_cnt), 32'd3);
    rs_addr = 5'd7; rt_addr = 5'd31;
    #1;
    chk("multi_rt_stall", 32'(stall), 32'd1);
    chk("multi_data1R", data1R, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_regfile_wb_port

`default_nettype wire
